// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port memory arbiter for fetch and load/store requesters
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_valid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_gnt,
    output logic                d_valid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int SC_W  = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] LAT_LOAD   = CNT_W'(MEM_LAT - 1);
    localparam logic [SC_W-1:0]  STARVE_TOP = SC_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   lat_cnt, lat_cnt_nxt;
    logic [SC_W-1:0]    starve_cnt, starve_nxt;
    logic               owner_d, owner_d_nxt;

    logic               if_gnt_nxt, if_valid_nxt, d_gnt_nxt, d_valid_nxt;
    logic [DATA_W-1:0]  if_rdata_nxt, d_rdata_nxt;
    logic               mem_en_nxt, mem_we_nxt;
    logic [BE_W-1:0]    mem_be_nxt;
    logic [ADDR_W-1:0]  mem_addr_nxt;
    logic [DATA_W-1:0]  mem_wdata_nxt;

    logic               arb, win_d, win_i, last_beat;

    // Fetches are always word aligned, so the low address bits are dropped.
    logic               unused_addr_bits;
    assign unused_addr_bits = ^if_addr[1:0];

    always_comb begin
        arb       = (state == IDLE) || (state == RESP);
        win_d     = arb && d_req && (!if_req || (starve_cnt != STARVE_TOP));
        win_i     = arb && if_req && !win_d;
        last_beat = (state == BUSY) && (lat_cnt == '0);

        state_nxt     = state;
        lat_cnt_nxt   = lat_cnt;
        starve_nxt    = starve_cnt;
        owner_d_nxt   = owner_d;
        if_gnt_nxt    = win_i;
        d_gnt_nxt     = win_d;
        if_valid_nxt  = last_beat && !owner_d;
        d_valid_nxt   = last_beat && owner_d;
        if_rdata_nxt  = if_rdata;
        d_rdata_nxt   = d_rdata;
        mem_en_nxt    = 1'b0;
        mem_we_nxt    = 1'b0;
        mem_be_nxt    = '0;
        mem_addr_nxt  = '0;
        mem_wdata_nxt = '0;

        case (state)
            BUSY: begin
                if (last_beat) begin
                    state_nxt = RESP;
                    if (!owner_d) begin
                        if_rdata_nxt = mem_rdata;
                    end else if (!mem_we) begin
                        d_rdata_nxt = mem_rdata;
                    end
                end else begin
                    lat_cnt_nxt   = lat_cnt - 1'b1;
                    mem_en_nxt    = 1'b1;
                    mem_we_nxt    = mem_we;
                    mem_be_nxt    = mem_be;
                    mem_addr_nxt  = mem_addr;
                    mem_wdata_nxt = mem_wdata;
                end
            end
            IDLE, RESP: state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase

        // Starvation only counts data wins that actually held off a waiting fetch.
        if (arb) begin
            if (win_i || !if_req) begin
                starve_nxt = '0;
            end else if (win_d && (starve_cnt != STARVE_TOP)) begin
                starve_nxt = starve_cnt + 1'b1;
            end
        end

        if (win_d || win_i) begin
            state_nxt   = BUSY;
            lat_cnt_nxt = LAT_LOAD;
            owner_d_nxt = win_d;
            mem_en_nxt  = 1'b1;
            if (win_d) begin
                mem_we_nxt    = d_we;
                mem_be_nxt    = d_be;
                mem_addr_nxt  = d_addr;
                mem_wdata_nxt = d_wdata;
            end else begin
                mem_we_nxt    = 1'b0;
                mem_be_nxt    = '1;
                mem_addr_nxt  = {if_addr[ADDR_W-1:2], 2'b00};
                mem_wdata_nxt = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            lat_cnt    <= '0;
            starve_cnt <= '0;
            owner_d    <= 1'b0;
            if_gnt     <= 1'b0;
            if_valid   <= 1'b0;
            if_rdata   <= '0;
            d_gnt      <= 1'b0;
            d_valid    <= 1'b0;
            d_rdata    <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_be     <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            state      <= state_nxt;
            lat_cnt    <= lat_cnt_nxt;
            starve_cnt <= starve_nxt;
            owner_d    <= owner_d_nxt;
            if_gnt     <= if_gnt_nxt;
            if_valid   <= if_valid_nxt;
            if_rdata   <= if_rdata_nxt;
            d_gnt      <= d_gnt_nxt;
            d_valid    <= d_valid_nxt;
            d_rdata    <= d_rdata_nxt;
            mem_en     <= mem_en_nxt;
            mem_we     <= mem_we_nxt;
            mem_be     <= mem_be_nxt;
            mem_addr   <= mem_addr_nxt;
            mem_wdata  <= mem_wdata_nxt;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized scoreboard bench for mem_arbiter
module tb_mem_arbiter;

    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 2;
    localparam int N_REQ      = 60;

    logic        clk, rst;
    logic        if_req, if_gnt, if_valid;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_gnt, d_valid;
    logic [3:0]  d_be;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        mem_en, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic        b_if_req, b_if_gnt, b_if_valid;
    logic [31:0] b_if_addr, b_if_rdata;
    logic        b_d_req, b_d_we, b_d_gnt, b_d_valid;
    logic [3:0]  b_d_be;
    logic [31:0] b_d_addr, b_d_wdata, b_d_rdata;
    logic        b_mem_en, b_mem_we;
    logic [3:0]  b_mem_be;
    logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(STARVE_MAX)) dut1 (
        .clk(clk), .rst(rst),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt), .if_valid(b_if_valid), .if_rdata(b_if_rdata),
        .d_req(b_d_req), .d_we(b_d_we), .d_be(b_d_be), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
        .d_gnt(b_d_gnt), .d_valid(b_d_valid), .d_rdata(b_d_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_be(b_mem_be), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
    );

    typedef struct {
        bit          is_d;
        logic [31:0] rdata;
        int          due;
    } resp_t;

    resp_t       sb[$];
    resp_t       r;
    int          total = 0, bad = 0, cyc = 0;
    bit          mon_on = 0, run = 0;
    int          f_left = N_REQ, d_left = N_REQ;
    logic [31:0] phys[16];
    logic [31:0] refm[16];
    int          ph = 0;
    int          since = 1000, exp_g = 0, starve = 0;
    logic [31:0] e_addr, n_addr, e_wdata, n_wdata, last_ld = 0;
    logic        e_we, n_we;
    logic [3:0]  e_be, n_be;
    logic [1:0]  exp_v;
    bit          done;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Fetch requester
    initial forever begin
        @(posedge clk);
        #1;
        if (run) begin
            if (if_req && if_gnt) if_req = 0;
            if (!if_req && f_left > 0 && $urandom_range(0, 3) != 0) begin
                if_req  = 1;
                if_addr = 32'($urandom_range(0, 63));
                f_left--;
            end
        end
    end

    // Load/store requester
    initial forever begin
        @(posedge clk);
        #1;
        if (run) begin
            if (d_req && d_gnt) d_req = 0;
            if (!d_req && d_left > 0 && $urandom_range(0, 3) != 0) begin
                d_req   = 1;
                d_we    = 1'($urandom_range(0, 1));
                d_be    = 4'($urandom_range(1, 15));
                d_addr  = 32'($urandom_range(0, 63));
                d_wdata = $urandom;
                d_left--;
            end
        end
    end

    // Memory macro: data is only meaningful on the last enable cycle
    initial forever begin
        @(negedge clk);
        if (mem_en) ph++; else ph = 0;
        if (mem_en && ph == MEM_LAT) begin
            mem_rdata = phys[mem_addr[5:2]];
            if (mem_we)
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) phys[mem_addr[5:2]][8*b +: 8] = mem_wdata[8*b +: 8];
        end else begin
            mem_rdata = $urandom;
        end
    end

    // Reference model and scoreboard monitor
    initial forever begin
        @(negedge clk);
        if (mon_on) begin
            chk("if_gnt", if_gnt, exp_g == 1);
            chk("d_gnt", d_gnt, exp_g == 2);
            if (exp_g != 0) begin
                since   = 0;
                e_addr  = n_addr;
                e_we    = n_we;
                e_be    = n_be;
                e_wdata = n_wdata;
            end else if (since < 1000) begin
                since++;
            end
            exp_g = 0;

            chk("mem_en", mem_en, since < MEM_LAT);
            if (since < MEM_LAT) begin
                chk("mem_addr", mem_addr, e_addr);
                chk("mem_we", mem_we, e_we);
                chk("mem_be", mem_be, e_be);
                if (e_we) chk("mem_wdata", mem_wdata, e_wdata);
            end

            exp_v = 2'b00;
            if (sb.size() > 0 && sb[0].due == cyc) exp_v = sb[0].is_d ? 2'b01 : 2'b10;
            chk("valid", {if_valid, d_valid}, exp_v);
            if (exp_v != 2'b00) begin
                r = sb.pop_front();
                if (r.is_d) chk("d_rdata", d_rdata, r.rdata);
                else        chk("if_rdata", if_rdata, r.rdata);
            end

            if (since >= MEM_LAT) begin
                if (if_req && (!d_req || starve == STARVE_MAX)) exp_g = 1;
                else if (d_req)                                 exp_g = 2;
                if (exp_g == 1 || !if_req)     starve = 0;
                else if (starve < STARVE_MAX)  starve++;
                if (exp_g == 1) begin
                    n_addr  = if_addr & ~32'h3;
                    n_we    = 0;
                    n_be    = 4'hF;
                    n_wdata = 0;
                    r.is_d  = 0;
                    r.rdata = refm[if_addr[5:2]];
                end else if (exp_g == 2) begin
                    n_addr  = d_addr;
                    n_we    = d_we;
                    n_be    = d_be;
                    n_wdata = d_wdata;
                    r.is_d  = 1;
                    if (d_we) begin
                        for (int b = 0; b < 4; b++)
                            if (d_be[b]) refm[d_addr[5:2]][8*b +: 8] = d_wdata[8*b +: 8];
                        r.rdata = last_ld;
                    end else begin
                        r.rdata = refm[d_addr[5:2]];
                        last_ld = r.rdata;
                    end
                end
                if (exp_g != 0) begin
                    r.due = cyc + 1 + MEM_LAT;
                    sb.push_back(r);
                end
            end
        end
    end

    initial begin
        rst = 0;
        if_req = 0; if_addr = 0;
        d_req = 0; d_we = 0; d_be = 0; d_addr = 0; d_wdata = 0;
        mem_rdata = 0;
        b_if_req = 0; b_if_addr = 0;
        b_d_req = 0; b_d_we = 0; b_d_be = 0; b_d_addr = 0; b_d_wdata = 0;
        b_mem_rdata = 32'h1234_5678;
        for (int i = 0; i < 16; i++) begin
            phys[i] = $urandom;
            refm[i] = phys[i];
        end

        repeat (2) @(posedge clk);
        #1;
        chk("rst_if_gnt", if_gnt, 0);
        chk("rst_d_gnt", d_gnt, 0);
        chk("rst_if_valid", if_valid, 0);
        chk("rst_d_valid", d_valid, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_be", mem_be, 0);
        rst    = 1;
        mon_on = 1;
        run    = 1;

        done = 0;
        for (int i = 0; i < 20000 && !done; i++) begin
            @(posedge clk);
            done = (f_left == 0) && (d_left == 0) && !if_req && !d_req;
        end
        chk("drain", done, 1);
        repeat (MEM_LAT + 4) @(posedge clk);
        chk("sb_empty", sb.size(), 0);
        #1;
        mon_on = 0;
        run    = 0;

        // Reset during the second enable cycle of a load
        d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h40;
        @(posedge clk);
        #1;
        chk("rt_d_gnt", d_gnt, 1);
        d_req = 0; if_req = 1; if_addr = 32'h8;
        @(posedge clk);
        #1;
        chk("rt_mem_en2", mem_en, 1);
        rst = 0;
        #1;
        chk("rt_mem_en", mem_en, 0);
        chk("rt_mem_addr", mem_addr, 0);
        chk("rt_d_valid", d_valid, 0);
        chk("rt_d_rdata", d_rdata, 0);
        chk("rt_if_rdata", if_rdata, 0);
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("rt_hold_d_valid", d_valid, 0);
            chk("rt_hold_if_gnt", if_gnt, 0);
        end
        rst = 1;
        @(posedge clk);
        #1;
        chk("rt_if_gnt_after", if_gnt, 1);
        chk("rt_no_d_valid", d_valid, 0);
        if_req = 0;
        @(posedge clk);
        #1;
        chk("rt_if_valid_early", if_valid, 0);
        @(posedge clk);
        #1;
        chk("rt_if_valid", if_valid, 1);
        chk("rt_if_rdata_val", if_rdata, refm[2]);
        chk("rt_no_d_valid2", d_valid, 0);

        // Single-cycle latency instance
        b_d_req = 1; b_d_we = 0; b_d_be = 4'hF; b_d_addr = 32'h10;
        @(posedge clk);
        #1;
        chk("l1_d_gnt", b_d_gnt, 1);
        chk("l1_mem_en", b_mem_en, 1);
        chk("l1_mem_addr", b_mem_addr, 32'h10);
        b_d_req = 0;
        @(posedge clk);
        #1;
        chk("l1_d_valid", b_d_valid, 1);
        chk("l1_d_rdata", b_d_rdata, 32'h1234_5678);
        chk("l1_mem_en_off", b_mem_en, 0);
        @(posedge clk);
        #1;
        chk("l1_d_valid_off", b_d_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter and access sequencer for the multi-cycle CPU. It shares one unified memory between the instruction-fetch requester and the load/store requester. Each access is a fixed-latency memory transaction with a req/gnt/valid handshake. Data accesses have priority, bounded by a fetch anti-starvation counter. The block sits between the CPU's fetch/memory stages and the memory macro, replacing the separate per-stage memory enables.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width (byte enables = DATA_W/8)
- `MEM_LAT`, 2, cycles `mem_en` is held per access (≥1); memory data is valid on the last of them
- `STARVE_MAX`, 3, consecutive data wins over a waiting fetch before fetch is forced (≥1)

Ports:
- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `if_req`  in  1  fetch request, held until `if_gnt`
- `if_addr`  in  ADDR_W  fetch address, stable while `if_req`
- `if_gnt`  out  1  one-cycle grant to fetch
- `if_valid`  out  1  one-cycle fetch response strobe
- `if_rdata`  out  DATA_W  fetched word, valid with `if_valid`
- `d_req`  in  1  load/store request, held until `d_gnt`
- `d_we`  in  1  1 = store
- `d_be`  in  DATA_W/8  store byte enables
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  store data
- `d_gnt`  out  1  one-cycle grant to data port
- `d_valid`  out  1  one-cycle load data / store ack strobe
- `d_rdata`  out  DATA_W  load data, valid with `d_valid`
- `mem_en`  out  1  memory access active
- `mem_we`  out  1  memory write
- `mem_be`  out  DATA_W/8  memory byte enables
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  memory read data, sampled on last `mem_en` cycle

## Operation
- FSM states: IDLE, BUSY, RESP. Reset state is IDLE.
- Arbitration happens only in IDLE and RESP, on the sampled `if_req`/`d_req`:
  - Only one request: that requester wins.
  - Both request: data wins, unless `starve_cnt == STARVE_MAX`, in which case fetch wins.
  - `starve_cnt` increments when data wins while `if_req` is high. It clears when fetch wins or when `if_req` is low at a decision. It saturates at STARVE_MAX.
- On a win the block moves to BUSY. It latches owner, address, we, be and wdata, pulses the owner's gnt, and loads the latency counter with MEM_LAT-1.
- BUSY:
  - `mem_en=1`. `mem_addr`, `mem_we`, `mem_be`, `mem_wdata` come from the latched values.
  - A fetch owner drives `mem_we=0`, `mem_be` all ones, `mem_addr[1:0]=0`.
  - The counter decrements each cycle. At 0, `mem_rdata` is captured into the owner's rdata register (reads only) and the state moves to RESP.
- RESP: the owner's valid pulses for one cycle. A store's `d_valid` is a write ack and `d_rdata` holds its previous value. Arbitration runs in the same cycle; a win goes to BUSY, otherwise IDLE.
- Requests arriving in BUSY are not sampled until RESP. Requesters keep req asserted with stable fields until they see gnt, and must drop req the cycle after gnt unless they are issuing a new request.
- `if_gnt` and `d_gnt` are never high together, and neither are `if_valid` and `d_valid`.
- Reset low at any time:
  - The FSM returns to IDLE immediately and any in-flight access is abandoned with no valid.
  - All outputs, counters and rdata registers go to 0.
- After reset release, the first decision occurs in the first IDLE cycle.

## Timing
- All outputs are registered. Reset value of every output is 0.
- A request sampled in IDLE at cycle 0 gives:
  - gnt in cycle 1
  - `mem_en` in cycles 1..MEM_LAT
  - valid and rdata in cycle MEM_LAT+1
- Back-to-back throughput: one access per MEM_LAT+1 cycles, since the next gnt lands in cycle MEM_LAT+2.
- `mem_rdata` is sampled at the rising edge ending cycle MEM_LAT.
- Latency counter width is clog2(MEM_LAT). `starve_cnt` width is clog2(STARVE_MAX+1). Neither wraps.

## Test plan
(MEM_LAT=2, STARVE_MAX=2 unless stated)
- **Single fetch:** `if_req=1`, `if_addr=0x0000_0106` at cycle 0 with `mem_rdata=0x0050_0093` → `if_gnt` cycle 1; `mem_en` cycles 1–2 with `mem_addr=0x104`, `mem_we=0`, `mem_be=4'hF`; `if_valid` cycle 3 with `if_rdata=0x0050_0093`; `d_*` outputs stay 0.
- **Store:** `d_req=1`, `d_we=1`, `d_be=4'b0011`, `d_addr=0x200`, `d_wdata=0xDEAD_BEEF` → `d_gnt` cycle 1; `mem_we=1`, `mem_be=0011`, `mem_wdata=0xDEADBEEF` cycles 1–2; `d_valid` cycle 3; `d_rdata` unchanged.
- **Contention:** `if_req` and `d_req` held high continuously (re-asserted after each gnt) → grant order D, D, I, D, D, I; gnts spaced 3 cycles apart; `if_gnt` and `d_gnt` never coincide.
- **Back-to-back:** new `d_req` asserted during the RESP of a prior load → `d_valid` and the next arbitration in the same cycle; next `d_gnt` exactly one cycle later; no idle cycle.
- **Reset mid-access:** `rst` driven low during the 2nd `mem_en` cycle → all outputs 0 within that cycle, no valid pulse; after release a pending `if_req` is granted 1 cycle after the first IDLE.
- **MEM_LAT=1:** single load → `d_gnt` and `mem_en` cycle 1, `d_valid` cycle 2.
